// File: rtl/keygen_seq.sv
`default_nettype none
// ============================================================================
// Module      : keygen_seq
// Description : Sequences one key-set generation (RNG, then private key),
//               validates the result, retries on failure or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module keygen_seq #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
    parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    output logic [1:0]  en,
    input  logic        rng_flag,
    input  logic        pkg_complete,
    input  logic [23:0] e_in,
    input  logic [23:0] n_in,
    input  logic [23:0] totient_in,
    input  logic [23:0] d_in,
    output logic [23:0] e_key,
    output logic [23:0] n_key,
    output logic [23:0] d_key,
    output logic        busy,
    output logic        key_valid,
    output logic        key_err,
    output logic [1:0]  retry_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT_RNG = 3'd2;
    localparam logic [2:0] S_WAIT_PKG = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;
    localparam logic [2:0] S_RETRY    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] S_ERROR    = 3'd7;

    localparam logic [15:0] C_TIMER_LAST = TIMEOUT_CYCLES - 16'd1;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_timer;
    logic [1:0]  r_retry_cnt;
    logic        r_key_valid;
    logic        r_key_err;
    logic [23:0] r_e_key;
    logic [23:0] r_n_key;
    logic [23:0] r_d_key;
    logic        w_timeout;
    logic        w_check_pass;
    logic        w_retry_left;

    assign w_timeout    = (r_timer == C_TIMER_LAST);
    assign w_check_pass = (e_in > 24'd1) && (e_in < totient_in) &&
                          (d_in != 24'd0) && (d_in < totient_in);
    assign w_retry_left = (r_retry_cnt < MAX_RETRY);

    // Timeout is tested before the handshakes so it wins on a tie.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (start) w_state_nxt = S_ARM;
                S_ARM:      w_state_nxt = S_WAIT_RNG;
                S_WAIT_RNG: begin
                    if (w_timeout)     w_state_nxt = S_RETRY;
                    else if (rng_flag) w_state_nxt = S_WAIT_PKG;
                end
                S_WAIT_PKG: begin
                    if (w_timeout)         w_state_nxt = S_RETRY;
                    else if (pkg_complete) w_state_nxt = S_CHECK;
                end
                S_CHECK:    w_state_nxt = w_check_pass ? S_DONE : S_RETRY;
                S_RETRY:    w_state_nxt = w_retry_left ? S_ARM : S_ERROR;
                S_DONE:     w_state_nxt = S_IDLE;
                S_ERROR:    w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flags are set on the edge entering DONE/ERROR so they are visible there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= 16'd0;
            r_retry_cnt <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_err   <= 1'b0;
            r_e_key     <= 24'd0;
            r_n_key     <= 24'd0;
            r_d_key     <= 24'd0;
        end else if (clear) begin
            r_timer     <= 16'd0;
            r_key_valid <= 1'b0;
            r_key_err   <= 1'b0;
            r_e_key     <= 24'd0;
            r_n_key     <= 24'd0;
            r_d_key     <= 24'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_timer     <= 16'd0;
                        r_retry_cnt <= 2'd0;
                        r_key_valid <= 1'b0;
                        r_key_err   <= 1'b0;
                    end
                end
                S_WAIT_RNG, S_WAIT_PKG: begin
                    r_timer <= r_timer + 16'd1;
                end
                S_CHECK: begin
                    if (w_check_pass) begin
                        r_e_key     <= e_in;
                        r_n_key     <= n_in;
                        r_d_key     <= d_in;
                        r_key_valid <= 1'b1;
                    end
                end
                S_RETRY: begin
                    r_timer <= 16'd0;
                    if (w_retry_left) begin
                        r_retry_cnt <= r_retry_cnt + 2'd1;
                    end else begin
                        r_key_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign en        = ((r_state == S_ARM) || (r_state == S_WAIT_RNG)) ? 2'b01 : 2'b00;
    assign busy      = (r_state != S_IDLE);
    assign key_valid = r_key_valid;
    assign key_err   = r_key_err;
    assign retry_cnt = r_retry_cnt;
    assign e_key     = r_e_key;
    assign n_key     = r_n_key;
    assign d_key     = r_d_key;

endmodule
`default_nettype wire

// File: tb/tb_keygen_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_keygen_seq
// Description : Directed self-checking bench for keygen_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keygen_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [1:0]  en;
    logic        rng_flag;
    logic        pkg_complete;
    logic [23:0] e_in;
    logic [23:0] n_in;
    logic [23:0] totient_in;
    logic [23:0] d_in;
    logic [23:0] e_key;
    logic [23:0] n_key;
    logic [23:0] d_key;
    logic        busy;
    logic        key_valid;
    logic        key_err;
    logic [1:0]  retry_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    keygen_seq #(
        .TIMEOUT_CYCLES (16'd8),
        .MAX_RETRY      (2'd3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clear        (clear),
        .en           (en),
        .rng_flag     (rng_flag),
        .pkg_complete (pkg_complete),
        .e_in         (e_in),
        .n_in         (n_in),
        .totient_in   (totient_in),
        .d_in         (d_in),
        .e_key        (e_key),
        .n_key        (n_key),
        .d_key        (d_key),
        .busy         (busy),
        .key_valid    (key_valid),
        .key_err      (key_err),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        rng_flag = 1'b1; pkg_complete = 1'b1;
        e_in = 24'd5; n_in = 24'd6; totient_in = 24'd9; d_in = 24'd2;
        step(2);
        tests_run++; if (en !== 2'b00) begin tests_failed++; $display("FAIL reset_en: got %b want 00", en); end
        tests_run++; if ({busy, key_valid, key_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {busy, key_valid, key_err}); end
        tests_run++; if (retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        tests_run++; if ({e_key, n_key, d_key} !== 72'd0) begin tests_failed++; $display("FAIL reset_keys: got %h want 0", {e_key, n_key, d_key}); end
        rng_flag = 1'b0; pkg_complete = 1'b0;
        rst_n = 1'b1;
        step(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_nominal();
        e_in = 24'd17; n_in = 24'd3233; totient_in = 24'd3120; d_in = 24'd2753;
        start = 1'b1;
        step(1);                                     // T+1 ARM
        start = 1'b0;
        tests_run++; if (en !== 2'b01 || busy !== 1'b1) begin tests_failed++; $display("FAIL nom_arm: got en=%b busy=%b want en=01 busy=1", en, busy); end
        step(1);                                     // T+2 WAIT_RNG
        tests_run++; if (en !== 2'b01) begin tests_failed++; $display("FAIL nom_wait_rng_en: got %b want 01", en); end
        step(2);                                     // T+4
        rng_flag = 1'b1;
        step(1);                                     // T+5 WAIT_PKG
        rng_flag = 1'b0;
        tests_run++; if (en !== 2'b00 || busy !== 1'b1) begin tests_failed++; $display("FAIL nom_wait_pkg: got en=%b busy=%b want en=00 busy=1", en, busy); end
        step(2);                                     // T+7
        pkg_complete = 1'b1;
        step(1);                                     // T+8 CHECK
        pkg_complete = 1'b0;
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL nom_check_valid: got %b want 0", key_valid); end
        step(1);                                     // T+9 DONE
        tests_run++; if (key_valid !== 1'b1) begin tests_failed++; $display("FAIL nom_done_valid: got %b want 1", key_valid); end
        tests_run++; if (e_key !== 24'd17 || n_key !== 24'd3233 || d_key !== 24'd2753) begin tests_failed++; $display("FAIL nom_keys: got %0d/%0d/%0d want 17/3233/2753", e_key, n_key, d_key); end
        step(1);                                     // T+10 IDLE
        tests_run++; if (busy !== 1'b0 || key_valid !== 1'b1 || retry_cnt !== 2'd0) begin tests_failed++; $display("FAIL nom_idle: got busy=%b valid=%b retry=%0d want 0/1/0", busy, key_valid, retry_cnt); end
    endtask

    task automatic test_latency();
        e_in = 24'd3; n_in = 24'd33; totient_in = 24'd20; d_in = 24'd7;
        rng_flag = 1'b1; pkg_complete = 1'b1;
        start = 1'b1;
        step(1);                                     // T+1
        start = 1'b0;
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_start_clears_valid: got %b want 0", key_valid); end
        step(2);                                     // T+3 WAIT_PKG
        tests_run++; if (en !== 2'b00 || busy !== 1'b1) begin tests_failed++; $display("FAIL lat_t3: got en=%b busy=%b want 00/1", en, busy); end
        step(1);                                     // T+4 CHECK
        tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_t4_valid: got %b want 0", key_valid); end
        step(1);                                     // T+5 DONE
        tests_run++; if (key_valid !== 1'b1 || d_key !== 24'd7) begin tests_failed++; $display("FAIL lat_t5: got valid=%b d=%0d want 1/7", key_valid, d_key); end
        step(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lat_idle_busy: got %b want 0", busy); end
        rng_flag = 1'b0; pkg_complete = 1'b0;
    endtask

    task automatic test_retry();
        e_in = 24'd3; n_in = 24'd33; totient_in = 24'd20; d_in = 24'd0;
        rng_flag = 1'b1; pkg_complete = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);                                     // T+5 RETRY
        tests_run++; if (en !== 2'b00 || busy !== 1'b1) begin tests_failed++; $display("FAIL retry_state: got en=%b busy=%b want 00/1", en, busy); end
        tests_run++; if (d_key !== 24'd7) begin tests_failed++; $display("FAIL retry_key_held: got %0d want 7", d_key); end
        d_in = 24'd11;
        step(1);                                     // T+6 ARM
        tests_run++; if (en !== 2'b01 || retry_cnt !== 2'd1) begin tests_failed++; $display("FAIL retry_rearm: got en=%b retry=%0d want 01/1", en, retry_cnt); end
        step(4);                                     // T+10 DONE
        tests_run++; if (key_valid !== 1'b1 || d_key !== 24'd11 || retry_cnt !== 2'd1) begin tests_failed++; $display("FAIL retry_pass: got valid=%b d=%0d retry=%0d want 1/11/1", key_valid, d_key, retry_cnt); end
        step(1);
        rng_flag = 1'b0; pkg_complete = 1'b0;
    endtask

    task automatic test_clear();
        e_in = 24'd3; n_in = 24'd33; totient_in = 24'd20; d_in = 24'd11;
        rng_flag = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);                                     // T+3 WAIT_PKG
        rng_flag = 1'b0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        tests_run++; if (busy !== 1'b0 || en !== 2'b00 || key_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_idle: got busy=%b en=%b valid=%b want 0/00/0", busy, en, key_valid); end
        tests_run++; if ({e_key, n_key, d_key} !== 72'd0) begin tests_failed++; $display("FAIL clear_keys: got %h want 0", {e_key, n_key, d_key}); end
        clear = 1'b1; start = 1'b1;
        step(1);
        clear = 1'b0; start = 1'b0;
        tests_run++; if (busy !== 1'b0 || en !== 2'b00) begin tests_failed++; $display("FAIL clear_wins_start: got busy=%b en=%b want 0/00", busy, en); end
        step(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL clear_wins_stays_idle: got %b want 0", busy); end
    endtask

    task automatic test_check_bounds();
        logic [23:0] ve [6];
        logic [23:0] vt [6];
        logic [23:0] vd [6];
        logic        vp [6];
        ve = '{24'd1, 24'd2, 24'd5, 24'd2, 24'd2, 24'hFFFFFE};
        vt = '{24'd9, 24'd3, 24'd5, 24'd5, 24'd5, 24'hFFFFFF};
        vd = '{24'd2, 24'd1, 24'd1, 24'd5, 24'd4, 24'hFFFFFE};
        vp = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        rng_flag = 1'b1; pkg_complete = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e_in = ve[i]; totient_in = vt[i]; d_in = vd[i]; n_in = 24'd100 + 24'(i);
            start = 1'b1;
            step(1);
            start = 1'b0;
            step(4);                                 // T+5: DONE on pass, RETRY on fail
            tests_run++; if (key_valid !== vp[i] || busy !== 1'b1) begin tests_failed++; $display("FAIL bounds_%0d: got valid=%b busy=%b want %b/1", i, key_valid, busy, vp[i]); end
            if (vp[i]) begin
                tests_run++; if (e_key !== ve[i] || d_key !== vd[i]) begin tests_failed++; $display("FAIL bounds_key_%0d: got %h/%h want %h/%h", i, e_key, d_key, ve[i], vd[i]); end
            end
            clear = 1'b1;
            step(1);
            clear = 1'b0;
        end
        rng_flag = 1'b0; pkg_complete = 1'b0;
    endtask

    task automatic test_timeout();
        rng_flag = 1'b0; pkg_complete = 1'b0;
        start = 1'b1;
        step(1);                                     // T+1 ARM
        start = 1'b0;
        step(8);                                     // T+9 last WAIT_RNG cycle
        tests_run++; if (en !== 2'b01) begin tests_failed++; $display("FAIL to_last_wait: got en=%b want 01", en); end
        rng_flag = 1'b1;                             // coincides with timeout
        step(1);                                     // T+10 RETRY
        rng_flag = 1'b0;
        tests_run++; if (en !== 2'b00 || busy !== 1'b1) begin tests_failed++; $display("FAIL to_retry: got en=%b busy=%b want 00/1", en, busy); end
        step(1);                                     // T+11 ARM
        tests_run++; if (en !== 2'b01 || retry_cnt !== 2'd1) begin tests_failed++; $display("FAIL to_precedence: got en=%b retry=%0d want 01/1", en, retry_cnt); end
        step(29);                                    // T+40 final RETRY
        tests_run++; if (key_err !== 1'b0 || busy !== 1'b1 || en !== 2'b00) begin tests_failed++; $display("FAIL to_final_retry: got err=%b busy=%b en=%b want 0/1/00", key_err, busy, en); end
        step(1);                                     // T+41 ERROR
        tests_run++; if (key_err !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL to_error: got err=%b busy=%b want 1/1", key_err, busy); end
        step(1);                                     // T+42 IDLE
        tests_run++; if (key_err !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0 || retry_cnt !== 2'd3) begin tests_failed++; $display("FAIL to_idle: got err=%b busy=%b valid=%b retry=%0d want 1/0/0/3", key_err, busy, key_valid, retry_cnt); end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        tests_run++; if (key_err !== 1'b0 || retry_cnt !== 2'd3) begin tests_failed++; $display("FAIL to_clear: got err=%b retry=%0d want 0/3", key_err, retry_cnt); end
    endtask

    task automatic test_start_busy();
        e_in = 24'd7; n_in = 24'd55; totient_in = 24'd40; d_in = 24'd23;
        start = 1'b1;
        step(1);                                     // T+1
        start = 1'b0;
        step(1);                                     // T+2 WAIT_RNG
        start = 1'b1;
        step(1);                                     // T+3
        start = 1'b0;
        rng_flag = 1'b1;
        step(1);                                     // T+4 WAIT_PKG
        rng_flag = 1'b0;
        pkg_complete = 1'b1;
        step(1);                                     // T+5 CHECK
        pkg_complete = 1'b0;
        step(1);                                     // T+6 DONE
        tests_run++; if (key_valid !== 1'b1 || retry_cnt !== 2'd0 || n_key !== 24'd55) begin tests_failed++; $display("FAIL busy_start_done: got valid=%b retry=%0d n=%0d want 1/0/55", key_valid, retry_cnt, n_key); end
        step(2);                                     // T+8
        tests_run++; if (busy !== 1'b0 || en !== 2'b00) begin tests_failed++; $display("FAIL busy_start_single_run: got busy=%b en=%b want 0/00", busy, en); end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);                                     // WAIT_RNG
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (en !== 2'b00 || busy !== 1'b0) begin tests_failed++; $display("FAIL async_rst: got en=%b busy=%b want 00/0", en, busy); end
        tests_run++; if ({e_key, n_key, d_key} !== 72'd0 || key_valid !== 1'b0) begin tests_failed++; $display("FAIL async_rst_keys: got %h valid=%b want 0/0", {e_key, n_key, d_key}, key_valid); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
        tests_run++; if (busy !== 1'b0 || key_valid !== 1'b0) begin tests_failed++; $display("FAIL async_rst_after: got busy=%b valid=%b want 0/0", busy, key_valid); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_latency();
        test_retry();
        test_clear();
        test_check_bounds();
        test_timeout();
        test_start_busy();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
